// File: rtl/alu_pkg.sv
// Shared types for the ALU32 execute stage.
// Optional feature: define ALU_OVF_EN to carry a signed-overflow flag with each beat.
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_AND  = 4'd0,
        ALU_OR   = 4'd1,
        ALU_XOR  = 4'd2,
        ALU_NOR  = 4'd3,
        ALU_ADD  = 4'd4,
        ALU_SUB  = 4'd5,
        ALU_SLT  = 4'd6,
        ALU_SLTU = 4'd7,
        ALU_SLL  = 4'd8,
        ALU_SRL  = 4'd9,
        ALU_SRA  = 4'd10
    } alu_op_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } skid_state_t;

    localparam int unsigned ALU_OP_LAST = 10;

    // Per-beat flags stored alongside the result in MAIN and SKID
    typedef struct packed {
        logic zero;
        logic illegal;
`ifdef ALU_OVF_EN
        logic ovf;
`endif
    } alu_flags_t;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: computes every unit's result and selects one per opcode.
// Optional feature: ALU_OVF_EN adds the ovf_c output.
module alu_core
    import alu_pkg::*;
#(
    parameter int unsigned N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [3:0]   op,
    output logic [N-1:0] y_c,
`ifdef ALU_OVF_EN
    output logic         ovf_c,
`endif
    output logic         illegal_c
);

    localparam int unsigned SHW = $clog2(N);

    logic [N-1:0]   sum;
    logic [N-1:0]   diff;
    logic [SHW-1:0] sh;
    logic           lt_s;
    logic           lt_u;

    assign sum  = a + b;
    assign diff = a - b;
    assign sh   = b[SHW-1:0];
    assign lt_s = $signed(a) < $signed(b);
    assign lt_u = a < b;

    // Result select; codes above ALU_OP_LAST yield zero and flag illegal
    always_comb begin
        y_c       = '0;
        illegal_c = 1'b0;
        case (alu_op_t'(op))
            ALU_AND:  y_c = a & b;
            ALU_OR:   y_c = a | b;
            ALU_XOR:  y_c = a ^ b;
            ALU_NOR:  y_c = ~(a | b);
            ALU_ADD:  y_c = sum;
            ALU_SUB:  y_c = diff;
            ALU_SLT:  y_c = N'(lt_s);
            ALU_SLTU: y_c = N'(lt_u);
            ALU_SLL:  y_c = a << sh;
            ALU_SRL:  y_c = a >> sh;
            ALU_SRA:  y_c = N'($signed(a) >>> sh);
            default:  illegal_c = 1'b1;
        endcase
    end

`ifdef ALU_OVF_EN
    // Signed overflow: result sign disagrees with what the operand signs imply
    always_comb begin
        ovf_c = 1'b0;
        case (alu_op_t'(op))
            ALU_ADD: ovf_c = (a[N-1] == b[N-1]) && (sum[N-1]  != a[N-1]);
            ALU_SUB: ovf_c = (a[N-1] != b[N-1]) && (diff[N-1] != a[N-1]);
            default: ovf_c = 1'b0;
        endcase
    end
`endif

endmodule

// File: rtl/alu_exec_stage.sv
// Registered ALU32 execute stage with valid/ready handshake and a 2-entry skid buffer.
// Optional feature: ALU_OVF_EN adds the out_ovf port and its storage.
module alu_exec_stage
    import alu_pkg::*;
#(
    parameter int unsigned N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_a,
    input  logic [N-1:0] in_b,
    input  logic [3:0]   in_op,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_y,
    output logic         out_zero,
`ifdef ALU_OVF_EN
    output logic         out_ovf,
`endif
    output logic         out_illegal
);

    logic [N-1:0] core_y;
    logic         core_illegal;
    alu_flags_t   core_flags;

    skid_state_t  state_q, state_d;
    logic         in_ready_q, in_ready_d;
    logic         out_valid_q, out_valid_d;
    logic [N-1:0] main_y_q, main_y_d;
    alu_flags_t   main_f_q, main_f_d;
    logic [N-1:0] skid_y_q, skid_y_d;
    alu_flags_t   skid_f_q, skid_f_d;

    logic         accept;
    logic         drain;

    alu_core #(.N(N)) u_core (
        .a         (in_a),
        .b         (in_b),
        .op        (in_op),
        .y_c       (core_y),
`ifdef ALU_OVF_EN
        .ovf_c     (core_flags.ovf),
`endif
        .illegal_c (core_illegal)
    );

    // Pack flags of the incoming beat; zero is taken from the result that gets stored
    always_comb begin
        core_flags.zero    = (core_y == '0);
        core_flags.illegal = core_illegal;
    end

    assign accept = in_valid && in_ready_q;
    assign drain  = out_valid_q && out_ready;

    // Skid FSM next state and MAIN/SKID load selection
    always_comb begin
        state_d  = state_q;
        main_y_d = main_y_q;
        main_f_d = main_f_q;
        skid_y_d = skid_y_q;
        skid_f_d = skid_f_q;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    main_y_d = core_y;
                    main_f_d = core_flags;
                    state_d  = ONE;
                end
            end
            ONE: begin
                if (accept && !drain) begin
                    skid_y_d = core_y;
                    skid_f_d = core_flags;
                    state_d  = FULL;
                end else if (accept && drain) begin
                    main_y_d = core_y;
                    main_f_d = core_flags;
                end else if (drain) begin
                    state_d  = EMPTY;
                end
            end
            FULL: begin
                if (drain) begin
                    main_y_d = skid_y_q;
                    main_f_d = skid_f_q;
                    state_d  = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
        out_valid_d = (state_d != EMPTY);
        in_ready_d  = (state_d != FULL);
    end

    // State, handshake and payload registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            main_y_q    <= '0;
            main_f_q    <= '0;
            skid_y_q    <= '0;
            skid_f_q    <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            main_y_q    <= main_y_d;
            main_f_q    <= main_f_d;
            skid_y_q    <= skid_y_d;
            skid_f_q    <= skid_f_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_y       = main_y_q;
    assign out_zero    = main_f_q.zero;
    assign out_illegal = main_f_q.illegal;
`ifdef ALU_OVF_EN
    assign out_ovf     = main_f_q.ovf;
`endif

endmodule
